// File: rtl/decode_stage.sv
// Decode stage: classifies 16/32-bit instructions from fetch, extracts fields and
// immediate, flags illegal encodings and holds the result in a one-entry output register.
module decode_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    input  logic                  instr_valid_i,
    output logic [1:0]            consumed_len_o,
    output logic                  fetch_req_o,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    output logic                  id_valid_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [WORD_WIDTH-1:0] id_instr_o,
    output logic                  id_compressed_o,
    output logic [6:0]            id_opcode_o,
    output logic [2:0]            id_funct3_o,
    output logic [4:0]            id_rd_o,
    output logic [4:0]            id_rs1_o,
    output logic [4:0]            id_rs2_o,
    output logic [31:0]           id_imm_o,
    output logic                  id_illegal_o,
    output logic                  halted_o
);

    typedef enum logic {RUN, HALT} state_t;

    state_t state_q, state_d;

    function automatic logic signed [31:0] imm_sel(input logic [31:0] i);
        logic signed [31:0] imm;
        imm = '0;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                imm = {{20{i[31]}}, i[31:20]};
            7'b0100011:
                imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011:
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {i[31:12], 12'b0};
            7'b1101111:
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic opcode_legal(input logic [6:0] op);
        logic legal;
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011:
                legal = 1'b1;
            default:
                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Stage p0: combinational decode of the instruction presented by fetch
    logic                   is32_p0;
    logic [WORD_WIDTH-1:0]  instr_p0;
    logic signed [31:0]     imm_p0;
    logic                   illegal_p0;
    logic                   accept_p0;

    // Output register
    logic                   vld_p1;
    logic [ADDR_WIDTH-1:0]  pc_p1;
    logic [WORD_WIDTH-1:0]  instr_p1;
    logic                   comp_p1;
    logic [6:0]             opcode_p1;
    logic [2:0]             funct3_p1;
    logic [4:0]             rd_p1;
    logic [4:0]             rs1_p1;
    logic [4:0]             rs2_p1;
    logic signed [31:0]     imm_p1;
    logic                   illegal_p1;

    assign is32_p0    = (instr_i[1:0] == 2'b11);
    assign instr_p0   = is32_p0 ? instr_i : {{(WORD_WIDTH-16){1'b0}}, instr_i[15:0]};
    assign imm_p0     = is32_p0 ? imm_sel(instr_p0[31:0]) : '0;
    assign illegal_p0 = (instr_i[15:0] == 16'h0000)
                      | (instr_i[31:0] == 32'hFFFF_FFFF)
                      | (is32_p0 & !opcode_legal(instr_i[6:0]));

    // Gating with rst_n keeps the fetch handshake quiet while reset is held
    assign accept_p0 = rst_n & instr_valid_i & (state_q == RUN) & !flush_i
                     & (!vld_p1 | ex_ready_i);

    assign consumed_len_o = !accept_p0 ? 2'd0 : (is32_p0 ? 2'd2 : 2'd1);
    assign fetch_req_o    = rst_n & (state_q == RUN) & !flush_i;
    assign halted_o       = (state_q == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept_p0 && illegal_p0) state_d = HALT;
            HALT:    if (flush_i)                 state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Stage p0 -> p1: load on accept, drain on ready, flush dominates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            instr_p1   <= '0;
            comp_p1    <= 1'b0;
            opcode_p1  <= '0;
            funct3_p1  <= '0;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            imm_p1     <= '0;
            illegal_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1     <= 1'b1;
            pc_p1      <= instr_addr_i;
            instr_p1   <= instr_p0;
            comp_p1    <= !is32_p0;
            opcode_p1  <= is32_p0 ? instr_p0[6:0] : 7'd0;
            funct3_p1  <= instr_p0[14:12];
            rd_p1      <= instr_p0[11:7];
            rs1_p1     <= instr_p0[19:15];
            rs2_p1     <= instr_p0[24:20];
            imm_p1     <= imm_p0;
            illegal_p1 <= illegal_p0;
        end else if (ex_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign id_valid_o      = vld_p1;
    assign id_pc_o         = pc_p1;
    assign id_instr_o      = instr_p1;
    assign id_compressed_o = comp_p1;
    assign id_opcode_o     = opcode_p1;
    assign id_funct3_o     = funct3_p1;
    assign id_rd_o         = rd_p1;
    assign id_rs1_o        = rs1_p1;
    assign id_rs2_o        = rs2_p1;
    assign id_imm_o        = imm_p1;
    assign id_illegal_o    = illegal_p1;

endmodule
